// File: rtl/prog_delay_buf_pkg.sv
// Shared types and helpers for the programmable delay line.
// FILL/RUN state encoding, constant clog2, delay clamp.
package prog_delay_buf_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Requested delays outside 1..max are pinned to the nearest legal value
  function automatic int dly_clamp(input int d, input int max);
    if (d < 1) return 1;
    if (d > max) return max;
    return d;
  endfunction

endpackage

// File: rtl/prog_delay_buf_mem.sv
// Simple dual-port storage: synchronous write, combinational read.
// Read-before-write on the same edge falls out of the async read.
module prog_delay_buf_mem #(
  parameter int W     = 9,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_delay_buf.sv
// Runtime-programmable delay line over a circular buffer with fill tracking.
// Optional synchronous flush port clr when DELAY_BUF_CLR_EN is defined.
module prog_delay_buf
  import prog_delay_buf_pkg::*;
#(
  parameter int DW        = 8,
  parameter int MAX_DEPTH = 128,
  parameter int DEF_DELAY = 8,
  localparam int AW       = clog2(MAX_DEPTH),
  localparam int DLW      = AW + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           dly_ld,
  input  logic [DLW-1:0] dly_i,
  input  logic [DW-1:0]  din,
  input  logic           din_vld,
`ifdef DELAY_BUF_CLR_EN
  input  logic           clr,
`endif
  output logic [DW-1:0]  dout,
  output logic           dout_vld,
  output logic           primed
);

  state_t         st, st_nxt, st_base;
  logic [AW-1:0]  wp, rd_addr;
  logic [DLW-1:0] dly_r, dly_nxt, cnt, cnt_nxt, cnt_base;
  logic [DW:0]    rd_data, pipe, out_q, out_nxt;
  logic           we;

  // A load takes effect on its own edge, so everything below uses dly_nxt
  assign dly_nxt = dly_ld ? DLW'(dly_clamp(int'(dly_i), MAX_DEPTH)) : dly_r;
  assign rd_addr = wp - AW'(dly_nxt - DLW'(1));
  assign pipe    = (dly_nxt == DLW'(1)) ? {din_vld, din} : rd_data;

  prog_delay_buf_mem #(.W(DW + 1), .DEPTH(MAX_DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wp),
    .wdata ({din_vld, din}),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    st_base  = dly_ld ? FILL : st;
    cnt_base = dly_ld ? '0 : cnt;
    st_nxt   = st_base;
    cnt_nxt  = cnt_base;
    out_nxt  = out_q;
    we       = 1'b0;
    if (en) begin
      we = 1'b1;
      if (st_base == RUN || cnt_base == dly_nxt - DLW'(1)) begin
        out_nxt = pipe;
        st_nxt  = RUN;
      end else begin
        out_nxt = '0;
        cnt_nxt = cnt_base + DLW'(1);
      end
    end
`ifdef DELAY_BUF_CLR_EN
    if (clr) begin
      st_nxt  = FILL;
      cnt_nxt = '0;
      out_nxt = '0;
      we      = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= FILL;
      cnt   <= '0;
      wp    <= '0;
      dly_r <= DLW'(DEF_DELAY);
      out_q <= '0;
    end else begin
      st    <= st_nxt;
      cnt   <= cnt_nxt;
      dly_r <= dly_nxt;
      out_q <= out_nxt;
      if (we) wp <= wp + AW'(1);
    end
  end

  assign {dout_vld, dout} = out_q;
  assign primed           = (st == RUN);

endmodule

// File: tb/tb_prog_delay_buf.sv
// Randomized bench for prog_delay_buf against a sample-history reference model.
// Covers reset, D=1, max delay/wrap, clamping, stalls, reloads, async reset, clr.
module tb_prog_delay_buf;
  localparam int DW = 8, MAXD = 128, AW = 7;

  logic clk = 1'b0, rst, en, dly_ld, din_vld;
  logic [AW:0] dly_i;
  logic [DW-1:0] din, dout;
  logic dout_vld, primed;
`ifdef DELAY_BUF_CLR_EN
  logic clr;
`endif

  prog_delay_buf #(.DW(DW), .MAX_DEPTH(MAXD), .DEF_DELAY(8)) dut (
    .clk(clk), .rst(rst), .en(en), .dly_ld(dly_ld), .dly_i(dly_i),
    .din(din), .din_vld(din_vld),
`ifdef DELAY_BUF_CLR_EN
    .clr(clr),
`endif
    .dout(dout), .dout_vld(dout_vld), .primed(primed)
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;
  // Model: every enabled-edge input since reset, edges since last flush, current D
  logic [DW:0] hist [0:4095];
  int k, since, D;
  logic [DW:0] exp_out;

  function automatic int mclamp(input int d);
    if (d < 1) return 1;
    if (d > MAXD) return MAXD;
    return d;
  endfunction

  task automatic model_reset();
    k = 0; since = 0; D = 8; exp_out = '0;
  endtask

  task automatic chk(input string tag);
    compared++;
    assert ({dout_vld, dout} === exp_out) else begin
      mismatched++;
      $error("FAIL %s out: got %h want %h", tag, {dout_vld, dout}, exp_out);
    end
    compared++;
    assert (primed === (since >= D)) else begin
      mismatched++;
      $error("FAIL %s primed: got %b want %b", tag, primed, since >= D);
    end
  endtask

  task automatic step(input string tag, input logic e, input logic ld, input int dly,
                      input logic [DW-1:0] d, input logic v, input logic c);
    en = e; dly_ld = ld; dly_i = dly[AW:0]; din = d; din_vld = v;
`ifdef DELAY_BUF_CLR_EN
    clr = c;
`endif
    @(posedge clk);
    if (ld) begin D = mclamp(dly); since = 0; end
`ifdef DELAY_BUF_CLR_EN
    if (c) begin since = 0; exp_out = '0; end
    else
`endif
    if (e) begin
      hist[k] = {v, d};
      since++;
      exp_out = (since >= D) ? hist[k - (D - 1)] : '0;
      k++;
    end
    #1;
    dly_ld = 1'b0;
`ifdef DELAY_BUF_CLR_EN
    clr = 1'b0;
`endif
    chk(tag);
  endtask

  task automatic rnd(input string tag, input int n, input int en_pct);
    for (int i = 0; i < n; i++)
      step(tag, ($urandom_range(99) < en_pct), 1'b0, 0, DW'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic async_rst(input string tag);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 0; dly_ld = 0; dly_i = '0; din = '0; din_vld = 0;
`ifdef DELAY_BUF_CLR_EN
    clr = 1'b0;
`endif
    model_reset();
    #12;
    chk("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 1; i <= 20; i++) step("ramp", 1'b1, 1'b0, 0, DW'(i), 1'b1, 1'b0);

    step("d1_load", 1'b1, 1'b1, 1, 8'h11, 1'b1, 1'b0);
    step("d1_a5", 1'b1, 1'b0, 0, 8'hA5, 1'b1, 1'b0);
    rnd("d1_rnd", 10, 100);

    step("ld200", 1'b1, 1'b1, 200, DW'($urandom), 1'b1, 1'b0);
    rnd("max_wrap", 300, 100);
    step("ld0", 1'b1, 1'b1, 0, DW'($urandom), 1'b1, 1'b0);
    rnd("clamp1", 8, 100);
    step("ld128_stall", 1'b0, 1'b1, 128, 8'h00, 1'b0, 1'b0);
    rnd("max_stall", 160, 70);

    step("ld4", 1'b1, 1'b1, 4, DW'($urandom), 1'b1, 1'b0);
    rnd("stall4", 200, 50);

    step("ld8", 1'b1, 1'b1, 8, DW'($urandom), 1'b1, 1'b0);
    rnd("pre_reload", 30, 100);
    step("reload3", 1'b1, 1'b1, 3, DW'($urandom), 1'b1, 1'b0);
    rnd("post_reload", 20, 100);
    step("ld_noen", 1'b0, 1'b1, 5, 8'h00, 1'b0, 1'b0);
    rnd("after_ld_noen", 20, 80);

    async_rst("async_rst");
    rnd("after_rst", 25, 100);

`ifdef DELAY_BUF_CLR_EN
    step("ld6", 1'b1, 1'b1, 6, DW'($urandom), 1'b1, 1'b0);
    rnd("pre_clr", 15, 100);
    step("clr", 1'b1, 1'b0, 0, DW'($urandom), 1'b1, 1'b1);
    rnd("post_clr", 20, 100);
    step("clr_ld", 1'b1, 1'b1, 8, DW'($urandom), 1'b1, 1'b1);
    rnd("post_clr_ld", 20, 100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
